// File: rtl/gpr_regfile.sv
// Integer register file: 32 ARCH_WIDTH-bit registers with two combinational read ports
// and one clocked write port. x0 is hard-wired to zero.

module gpr_cell #(
    parameter int                    ARCH_WIDTH  = 64,
    parameter logic [ARCH_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  writeEnable,
    input  logic [ARCH_WIDTH-1:0] writeData,
    input  logic                  readOnly,
    output logic [ARCH_WIDTH-1:0] readData
);
    logic [ARCH_WIDTH-1:0] data_r;

    // Storage: async reset loads the per-instance index value; read-only cells never update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= RESET_VALUE;
        end else if (writeEnable && !readOnly) begin
            data_r <= writeData;
        end else begin
            data_r <= data_r;
        end
    end

    assign readData = data_r;
endmodule

module gpr_mux #(
    parameter int ARCH_WIDTH     = 64,
    parameter int INPUT_QUANTITY = 32,
    parameter int SEL_WIDTH      = 5
) (
    input  logic [ARCH_WIDTH-1:0] inputs [INPUT_QUANTITY],
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [ARCH_WIDTH-1:0] result
);
    // Selection: out-of-range indices yield zero so the output is never undefined.
    always_comb begin
        result = '0;
        if (32'(sel) < INPUT_QUANTITY) begin
            result = inputs[sel];
        end else begin
            result = '0;
        end
    end
endmodule

module gpr_regfile #(
    parameter int ARCH_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    input  logic                  wEn,
    input  logic                  immediate,
    input  logic [ARCH_WIDTH-1:0] wData,
    output logic [ARCH_WIDTH-1:0] out1,
    output logic [ARCH_WIDTH-1:0] out2
);
    logic [31:0]           we_s;
    logic [ARCH_WIDTH-1:0] cell_data_s [32];
    logic [ARCH_WIDTH-1:0] rd2_s;

    // Write-enable decode: one-hot of rd, gated by wEn.
    always_comb begin
        we_s = 32'd0;
        if (wEn) begin
            we_s = 32'd1 << rd;
        end else begin
            we_s = 32'd0;
        end
    end

    for (genvar i = 0; i < 32; i++) begin : g_cell
        gpr_cell #(
            .ARCH_WIDTH (ARCH_WIDTH),
            .RESET_VALUE(ARCH_WIDTH'(i))
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .writeEnable(we_s[i]),
            .writeData  (wData),
            .readOnly   ((i == 0) ? 1'b1 : 1'b0),
            .readData   (cell_data_s[i])
        );
    end

    gpr_mux #(
        .ARCH_WIDTH    (ARCH_WIDTH),
        .INPUT_QUANTITY(32),
        .SEL_WIDTH     (5)
    ) u_mux1 (
        .inputs(cell_data_s),
        .sel   (rs1),
        .result(out1)
    );

    gpr_mux #(
        .ARCH_WIDTH    (ARCH_WIDTH),
        .INPUT_QUANTITY(32),
        .SEL_WIDTH     (5)
    ) u_mux2 (
        .inputs(cell_data_s),
        .sel   (rs2),
        .result(rd2_s)
    );

    // Operand B: an immediate instruction suppresses the register value.
    always_comb begin
        out2 = '0;
        if (immediate) begin
            out2 = '0;
        end else begin
            out2 = rd2_s;
        end
    end
endmodule

// File: tb/tb_gpr_regfile.sv
// Scoreboard bench for gpr_regfile: directed scenarios plus random traffic checked
// against an array-based reference model.

module tb_gpr_regfile;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic        wEn = 1'b0;
    logic        immediate = 1'b0;
    logic [63:0] wData = 64'd0;
    logic [63:0] out1;
    logic [63:0] out2;

    typedef struct {
        string       name;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model [32];
    int          vectors = 0;
    int          miscompares = 0;

    gpr_regfile #(.ARCH_WIDTH(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .wEn      (wEn),
        .immediate(immediate),
        .wData    (wData),
        .out1     (out1),
        .out2     (out2)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are combinational, so each vector is checked mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors = vectors + 1;
            if (out1 !== e.exp1 || out2 !== e.exp2) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: got out1=%h out2=%h expected out1=%h out2=%h",
                         e.name, out1, out2, e.exp1, e.exp2);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 64'(i);
    endtask

    // One cycle: commit the write seen at this edge into the model, drive new inputs,
    // and queue what the outputs must show before the next edge.
    task automatic apply(input string name, input logic r, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic we,
                         input logic im, input logic [63:0] wd);
        exp_t e;
        @(posedge clk);
        if (rst_n && wEn && rd != 5'd0) model[rd] = wData;
        #1;
        rst_n = r; rs1 = a; rs2 = b; rd = d; wEn = we; immediate = im; wData = wd;
        if (!r) model_reset();
        e.name = name;
        e.exp1 = model[a];
        e.exp2 = im ? 64'd0 : model[b];
        sb_q.push_back(e);
    endtask

    initial begin
        model_reset();

        for (int i = 0; i < 32; i++)
            apply("reset_sweep", 1'b0, 5'(i), 5'(31 - i), 5'($urandom_range(31)),
                  1'b1, 1'b0, {$urandom, $urandom});

        apply("release", 1'b1, 5'd10, 5'd1, 5'd0, 1'b0, 1'b0, 64'd0);
        apply("write_old_value", 1'b1, 5'd10, 5'd2, 5'd10, 1'b1, 1'b0, 64'hDEAD_BEEF_0123_4567);
        apply("write_new_value", 1'b1, 5'd10, 5'd10, 5'd0, 1'b0, 1'b0, 64'd0);
        apply("x0_write", 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        apply("x0_read", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 64'd0);
        apply("wen_off", 1'b1, 5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 64'd7);
        apply("dual_read", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 64'd0);
        apply("immediate", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b1, 64'd0);
        apply("b2b_first", 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 64'd1);
        apply("b2b_second", 1'b1, 5'd31, 5'd30, 5'd31, 1'b1, 1'b0, 64'd2);
        apply("b2b_after", 1'b1, 5'd31, 5'd31, 5'd0, 1'b0, 1'b0, 64'd0);

        for (int i = 0; i < 300; i++)
            apply("random", 1'b1, 5'($urandom_range(31)), 5'($urandom_range(31)),
                  5'($urandom_range(31)), 1'($urandom), 1'($urandom_range(3) == 0),
                  {$urandom, $urandom});

        apply("x7_write", 1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 64'h55);
        apply("x7_read", 1'b1, 5'd7, 5'd9, 5'd7, 1'b1, 1'b0, 64'hAAAA);
        apply("async_reset", 1'b0, 5'd7, 5'd9, 5'd0, 1'b0, 1'b0, 64'd0);
        apply("post_reset", 1'b1, 5'd7, 5'd31, 5'd0, 1'b0, 1'b0, 64'd0);

        for (int i = 0; i < 50; i++)
            apply("random_tail", 1'($urandom_range(15) != 0), 5'($urandom_range(31)),
                  5'($urandom_range(31)), 5'($urandom_range(31)), 1'($urandom),
                  1'($urandom), {$urandom, $urandom});

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
